// File: rtl/int_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_seq_pkg
//  Description : Shared types, default constants and the priority-encode
//                helper for the interrupt sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package int_seq_pkg;

  // Defaults for the sequencer parameters
  localparam int          c_n_irq        = 6;
  localparam logic [31:0] c_handler_addr = 32'h0000_4180;
  localparam int          c_cnt_w        = 16;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ENTER   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    EXIT    = 3'd4
  } state_t;

  // Isolate the lowest set bit as a one-hot vector (bit 0 is highest
  // priority). Operates on a 32-bit container so any N_IRQ up to 32 can use
  // it through a width cast. An all-zero request yields all-zero.
  function automatic logic [31:0] prio_onehot(input logic [31:0] req);
    prio_onehot = req & (~req + 32'd1);
  endfunction

endpackage : int_seq_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync_edge
//  Description : One interrupt line: two-flop synchronizer, an extra stage
//                for rising-edge detection, and a pending latch for
//                edge-mode lines that is cleared by the sequencer's ack.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,     // raw asynchronous request
  input  logic edge_mode,  // 1 = rising-edge latched, 0 = level
  input  logic ack,        // sequencer is servicing this line this cycle
  output logic hwint       // this line's bit of the pending vector
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_pend;
  logic w_rise;

  // Rising edge seen on the synchronized signal
  assign w_rise = r_s2 & ~r_s3;

  // Synchronizer chain plus edge-detect delay stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= irq_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending latch: a new edge beats a same-cycle ack so no request is lost;
  // level lines keep no state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (!edge_mode) begin
      r_pend <= 1'b0;
    end else if (w_rise) begin
      r_pend <= 1'b1;
    end else if (ack) begin
      r_pend <= 1'b0;
    end
  end

  assign hwint = r_pend | (r_s2 & ~edge_mode);

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : int_seq
//  Description : Interrupt sequencer for the multi-cycle MIPS core. Builds
//                the CP0 HWInt vector from device lines, and at instruction
//                boundaries steps through handler entry (EXL set, stall,
//                redirect to the handler) and ERET return (EXL clear,
//                redirect to EPC).
//  Revision    : 1.0  initial release
// ============================================================================
module int_seq
  import int_seq_pkg::*;
#(
  parameter int          N_IRQ        = c_n_irq,
  parameter logic [31:0] HANDLER_ADDR = c_handler_addr,
  parameter int          CNT_W        = c_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_edge,
  output logic [N_IRQ-1:0] hwint,
  input  logic             intreq,
  input  logic             instr_end,
  input  logic             is_eret,
  input  logic [31:0]      cp0_epc,
  output logic             exlset,
  output logic             exlclr,
  output logic             hold,
  output logic             redirect,
  output logic [31:0]      npc,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [CNT_W-1:0] irq_count
);

  state_t           r_state;
  logic [CNT_W-1:0] r_irq_count;
  logic [N_IRQ-1:0] w_prio;

  // Per-line synchronizer / pending logic
  generate
    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
      irq_sync_edge u_line (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in[i]),
        .edge_mode (irq_edge[i]),
        .ack       (irq_ack[i]),
        .hwint     (hwint[i])
      );
    end
  endgenerate

  // Lowest-numbered pending line wins
  assign w_prio = N_IRQ'(prio_onehot(32'(hwint)));

  // Sequencer state: moves only at instruction boundaries or through the
  // fixed one-cycle entry/exit steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          // ERET has priority over a simultaneous request
          if (instr_end && is_eret) begin
            r_state <= EXIT;
          end else if (instr_end && intreq) begin
            r_state <= ENTER;
          end
        end
        ENTER:   r_state <= VECTOR;
        VECTOR:  r_state <= HANDLER;
        HANDLER: begin
          // No nesting: intreq is not looked at while in the handler
          if (instr_end && is_eret) begin
            r_state <= EXIT;
          end
        end
        EXIT:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating count of handler entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_count <= '0;
    end else if ((r_state == ENTER) && (r_irq_count != '1)) begin
      r_irq_count <= r_irq_count + CNT_W'(1);
    end
  end

  // Moore outputs decoded from the state register; npc in EXIT follows the
  // live EPC so the core sees the value CP0 holds in that cycle
  assign exlset    = (r_state == ENTER);
  assign hold      = (r_state == ENTER);
  assign exlclr    = (r_state == EXIT);
  assign redirect  = (r_state == VECTOR) || (r_state == EXIT);
  assign npc       = (r_state == VECTOR) ? HANDLER_ADDR :
                     (r_state == EXIT)   ? cp0_epc      : 32'h0;
  assign irq_ack   = (r_state == ENTER) ? w_prio : '0;
  assign irq_count = r_irq_count;

endmodule : int_seq
`default_nettype wire

// File: tb/tb_int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_seq
//  Description : Scoreboard bench for int_seq. Stimulus pushes the expected
//                sequencer outputs; a monitor pops one record for every
//                cycle in which the DUT asserts exlset/exlclr/hold/redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_seq;

  localparam int          N  = 6;
  localparam int          CW = 2;
  localparam logic [31:0] HA = 32'h0000_4180;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in, irq_edge, hwint, irq_ack;
  logic          intreq, instr_end, is_eret;
  logic [31:0]   cp0_epc, npc;
  logic          exlset, exlclr, hold, redirect;
  logic [CW-1:0] irq_count;

  logic force_req;
  logic tb_exl;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic          exlset;
    logic          exlclr;
    logic          hold;
    logic          redirect;
    logic [31:0]   npc;
    logic [N-1:0]  ack;
    logic [CW-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;

  int_seq #(.N_IRQ(N), .HANDLER_ADDR(HA), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_edge  (irq_edge),
    .hwint     (hwint),
    .intreq    (intreq),
    .instr_end (instr_end),
    .is_eret   (is_eret),
    .cp0_epc   (cp0_epc),
    .exlset    (exlset),
    .exlclr    (exlclr),
    .hold      (hold),
    .redirect  (redirect),
    .npc       (npc),
    .irq_ack   (irq_ack),
    .irq_count (irq_count)
  );

  always #5 clk = ~clk;

  // Minimal CP0: IE/IM open, request masked by EXL; force_req overrides
  assign intreq = force_req | ((|hwint) & ~tb_exl);

  always @(posedge clk or posedge rst) begin
    if (rst)         tb_exl <= 1'b0;
    else if (exlset) tb_exl <= 1'b1;
    else if (exlclr) tb_exl <= 1'b0;
  end

  // Monitor: every active sequencer cycle must match the next expectation
  always @(negedge clk) begin
    if (!rst && (exlset || exlclr || hold || redirect)) begin
      mon_act = {exlset, exlclr, hold, redirect, npc, irq_ack, irq_count};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: unexpected output got=%h (xs,xc,h,r,npc,ack,cnt) required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL event: got=%h required=%h (xs,xc,h,r,npc,ack,cnt)", mon_act, mon_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic eret);
    instr_end = 1'b1;
    is_eret   = eret;
    step();
    instr_end = 1'b0;
    is_eret   = 1'b0;
  endtask

  function automatic ev_t mk(input logic xs, input logic xc, input logic h, input logic r,
                             input logic [31:0] pc, input logic [N-1:0] ack, input logic [CW-1:0] cnt);
    return {xs, xc, h, r, pc, ack, cnt};
  endfunction

  // Queue ENTER + VECTOR records, take the entry, return positioned in VECTOR
  task automatic take_entry(input logic [N-1:0] ack, input logic [CW-1:0] c_enter, input logic [CW-1:0] c_vec);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ack, c_enter));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4180, '0, c_vec));
    instr(1'b0);
    step();
  endtask

  // From HANDLER: ERET, expect the EXIT record, return positioned in RUN
  task automatic do_return(input logic [31:0] epc, input logic [CW-1:0] cnt);
    cp0_epc = epc;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, epc, '0, cnt));
    instr(1'b1);
    step();
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_edge = '0; instr_end = 1'b0; is_eret = 1'b0;
    cp0_epc = 32'h0; force_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {exlset, exlclr, hold, redirect, irq_ack, npc, irq_count}, 64'h0);
    chk("reset_hwint", hwint, 64'h0);
    rst = 1'b0;
    step();

    // Level line 0: two-edge latency, entry, no nesting, return
    irq_in = 6'b000001;
    step();
    chk("lvl_lat1", hwint, 64'h0);
    step();
    chk("lvl_lat2", hwint, 64'h01);
    take_entry(6'b000001, 2'd0, 2'd1);
    step();
    irq_in = '0;
    force_req = 1'b1;
    instr(1'b0);
    force_req = 1'b0;
    chk("no_nest", {exlset, hold}, 64'h0);
    step();
    step();
    chk("lvl_drop", hwint, 64'h0);
    do_return(32'h0000_3008, 2'd1);
    chk("run_idle", {exlset, exlclr, hold, redirect}, 64'h0);

    // Edge line 2: three-edge latency, held until ack
    irq_edge = 6'b111110;
    step();
    irq_in[2] = 1'b1;
    step();
    irq_in[2] = 1'b0;
    chk("edge_lat1", hwint, 64'h0);
    step();
    chk("edge_lat2", hwint, 64'h0);
    step();
    chk("edge_lat3", hwint, 64'h04);
    repeat (3) step();
    chk("edge_held", hwint, 64'h04);
    take_entry(6'b000100, 2'd1, 2'd2);
    chk("edge_ack_clr", hwint, 64'h0);
    step();
    do_return(32'h0000_1234, 2'd2);

    // New edge detected in the ack cycle keeps the line pending
    irq_in[2] = 1'b1;
    step();
    irq_in[2] = 1'b0;
    repeat (4) step();
    chk("edge_pend2", hwint, 64'h04);
    step();
    irq_in[2] = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000100, 2'd2));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4180, '0, 2'd3));
    step();
    irq_in[2] = 1'b0;
    instr(1'b0);
    step();
    chk("set_wins", hwint, 64'h04);
    step();
    do_return(32'h0000_2000, 2'd3);

    // Fourth entry: counter saturates at 3
    take_entry(6'b000100, 2'd3, 2'd3);
    chk("sat_clr", hwint, 64'h0);
    chk("sat_cnt", irq_count, 64'h3);
    step();
    do_return(32'h0000_2004, 2'd3);

    // Priority: lines 1 and 3 pending, line 1 served first
    irq_in = 6'b001010;
    step();
    irq_in = '0;
    repeat (3) step();
    chk("prio_pend", hwint, 64'h0A);
    take_entry(6'b000010, 2'd3, 2'd3);
    chk("prio_after", hwint, 64'h08);
    step();
    do_return(32'h0000_2008, 2'd3);

    // ERET in RUN with intreq high: EXIT, no entry
    cp0_epc = 32'h0000_0500;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500, '0, 2'd3));
    instr(1'b1);
    chk("eret_wins", {exlset, exlclr}, 64'h1);
    step();

    // Asynchronous reset in the middle of ENTER (line 3 still pending)
    instr(1'b0);
    chk("enter_pre_rst", exlset, 64'h1);
    #1 rst = 1'b1;
    #1 chk("rst_async", {exlset, hold, irq_ack, irq_count, hwint}, 64'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("rst_run", {exlset, exlclr, hold, redirect}, 64'h0);
    cp0_epc = 32'h0000_0600;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0600, '0, 2'd0));
    instr(1'b1);
    step();

    repeat (2) step();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got=%0d outstanding required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_int_seq
`default_nettype wire
